iram_refill_responder: RTL and testbench

Memory-side responder for the instruction cache refill protocol. It answers a fetch-unit cache miss (`miss_cache` plus a word address on `ram_address`) by reading one full line from a synchronous instruction RAM. It returns the words one per beat on `mem_word`, each qualified by a one-cycle `word_ready` strobe. It is the synthesizable counterpart of the fetch unit's refill port and replaces behavioural RAM models in system builds.

---
 rtl/iram_refill_responder.sv | 163 ++++++++++++++++
 tb/tb_iram_refill_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_refill_responder.sv
// Instruction-RAM refill responder: on a cache miss it streams one full line out of a
// synchronous RAM, one word per strobe, with a programmable gap before every read.
module iram_refill_responder #(
  parameter  int WORD_SIZE   = 32,
  parameter  int ADDR_SIZE   = 32,
  parameter  int MEM_DEPTH   = 1024,
  parameter  int LINE_WORDS  = 4,
  parameter  int WAIT_CYCLES = 1,
  localparam int MEM_AW      = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 miss_cache,
  input  logic [ADDR_SIZE-1:0] ram_address,
  output logic                 word_ready,
  output logic [WORD_SIZE-1:0] mem_word,
  output logic                 line_done,
  output logic                 busy,
  output logic                 ram_rd_en,
  output logic [MEM_AW-1:0]    ram_rd_addr,
  input  logic [WORD_SIZE-1:0] ram_rd_data
);

  // Counters must be able to hold LINE_WORDS itself so "all issued" is representable.
  localparam int             CW        = $clog2(LINE_WORDS + 1);
  localparam logic [CW-1:0]  LINE_LEN  = CW'(LINE_WORDS);
  localparam logic [CW-1:0]  LAST_IDX  = CW'(LINE_WORDS - 1);
  localparam logic [3:0]     WAIT_LOAD = 4'(WAIT_CYCLES);

  generate
    if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("MEM_DEPTH must be a power of two >= 2");
    end
    if ((LINE_WORDS < 1) || (LINE_WORDS > 64) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : g_bad_line
      $error("LINE_WORDS must be a power of two in 1..64");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 0..15");
    end
    if (ADDR_SIZE < MEM_AW) begin : g_bad_addr
      $error("ADDR_SIZE must cover the RAM address width");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e               state_q,    state_d;
  logic [MEM_AW-1:0]    base_q,     base_d;
  logic [3:0]           wait_q,     wait_d;
  logic [CW-1:0]        issued_q,   issued_d;
  logic [CW-1:0]        returned_q, returned_d;
  logic                 rdValid_q,  rdValid_d;
  logic                 ready_q,    ready_d;
  logic [WORD_SIZE-1:0] memWord_q,  memWord_d;

  logic                 strobe;
  logic                 lastStrobe;
  logic                 rdEn;
  logic [MEM_AW-1:0]    rdAddr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      wait_q     <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      rdValid_q  <= 1'b0;
      ready_q    <= 1'b0;
      memWord_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      wait_q     <= wait_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      rdValid_q  <= rdValid_d;
      ready_q    <= ready_d;
      memWord_q  <= memWord_d;
    end
  end

  // Strobes are gated by the live request so an aborting fetch unit never sees a stray word.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    wait_d     = wait_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    rdValid_d  = 1'b0;
    ready_d    = 1'b0;
    memWord_d  = memWord_q;
    rdEn       = 1'b0;
    rdAddr     = '0;
    strobe     = ready_q & miss_cache;
    lastStrobe = strobe && (returned_q == LAST_IDX);

    unique case (state_q)
      IDLE: begin
        if (miss_cache) begin
          state_d    = BURST;
          base_d     = ram_address[MEM_AW-1:0];
          wait_d     = WAIT_LOAD;
          issued_d   = '0;
          returned_d = '0;
        end
      end

      BURST: begin
        if (!miss_cache) begin
          state_d    = IDLE;
          wait_d     = '0;
          issued_d   = '0;
          returned_d = '0;
        end else begin
          if ((wait_q == '0) && (issued_q < LINE_LEN)) begin
            rdEn     = 1'b1;
            rdAddr   = base_q + MEM_AW'(issued_q);
            issued_d = issued_q + 1'b1;
            wait_d   = WAIT_LOAD;
          end else if (wait_q != '0) begin
            wait_d = wait_q - 1'b1;
          end

          rdValid_d = rdEn;
          if (rdValid_q) begin
            memWord_d = ram_rd_data;
            ready_d   = 1'b1;
          end

          if (strobe) begin
            returned_d = returned_q + 1'b1;
          end
          if (lastStrobe) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (!miss_cache) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign word_ready  = strobe;
  assign line_done   = lastStrobe;
  assign mem_word    = memWord_q;
  assign busy        = (state_q != IDLE);
  assign ram_rd_en   = rdEn;
  assign ram_rd_addr = rdAddr;

endmodule

// File: tb/tb_iram_refill_responder.sv
// Scoreboard bench for iram_refill_responder: one instance with the default wait,
// one with zero wait; expected reads and beats are queued and checked by monitors.
module tb_iram_refill_responder;

  localparam int AW = 10;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          missA, missB;
  logic [31:0]   addrA, addrB;
  logic          wrA, ldA, busyA, reA;
  logic          wrB, ldB, busyB, reB;
  logic [31:0]   mwA, mwB, rdA, rdB;
  logic [AW-1:0] raA, raB;
  logic          reLatA, reLatB;
  logic [AW-1:0] raLatA, raLatB;

  int   cyc = 0;
  int   t0A = 0;
  int   t0B = 0;
  int   total = 0;
  int   bad = 0;
  exp_t readQA[$], beatQA[$], readQB[$], beatQB[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iram_refill_responder #(.WAIT_CYCLES(1)) dutA (
    .clk(clk), .nrst(nrst), .miss_cache(missA), .ram_address(addrA),
    .word_ready(wrA), .mem_word(mwA), .line_done(ldA), .busy(busyA),
    .ram_rd_en(reA), .ram_rd_addr(raA), .ram_rd_data(rdA)
  );

  iram_refill_responder #(.WAIT_CYCLES(0)) dutB (
    .clk(clk), .nrst(nrst), .miss_cache(missB), .ram_address(addrB),
    .word_ready(wrB), .mem_word(mwB), .line_done(ldB), .busy(busyB),
    .ram_rd_en(reB), .ram_rd_addr(raB), .ram_rd_data(rdB)
  );

  // Synchronous RAM models holding RAM[i] = 0xA000_0000 + i; request sampled mid-cycle.
  initial begin
    rdA = '0;
    rdB = '0;
    reLatA = 1'b0;
    reLatB = 1'b0;
    raLatA = '0;
    raLatB = '0;
  end
  always @(negedge clk) begin
    reLatA = reA;
    raLatA = raA;
    reLatB = reB;
    raLatB = raB;
  end
  always @(posedge clk) begin
    if (reLatA) rdA <= 32'hA000_0000 | 32'(raLatA);
    if (reLatB) rdB <= 32'hA000_0000 | 32'(raLatB);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand formula: read k at cycle 1+W+k*(W+1), its strobe two cycles later.
  function automatic void pushExpect(input bit dutB, input logic [AW-1:0] base, input int w,
                                     input int stopAt);
    for (int k = 0; k < 4; k++) begin
      exp_t          r, b;
      logic [AW-1:0] a;
      a      = base + AW'(k);
      r.cyc  = 1 + w + k * (w + 1);
      r.val  = 32'(a);
      r.last = 1'b0;
      b.cyc  = r.cyc + 2;
      b.val  = 32'hA000_0000 | 32'(a);
      b.last = (k == 3);
      if (r.cyc < stopAt) begin
        if (dutB) readQB.push_back(r); else readQA.push_back(r);
      end
      if (b.cyc < stopAt) begin
        if (dutB) beatQB.push_back(b); else beatQA.push_back(b);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (reA === 1'b1) begin
        if (readQA.size() == 0) checkOutput("A unexpected read", 64'(readQA.size()), 64'd1);
        else begin
          exp_t e;
          e = readQA.pop_front();
          checkOutput("A read cycle", 64'(cyc - t0A), 64'(e.cyc));
          checkOutput("A read addr", 64'(raA), 64'(e.val));
        end
      end
      if (wrA === 1'b1) begin
        if (beatQA.size() == 0) checkOutput("A unexpected strobe", 64'(beatQA.size()), 64'd1);
        else begin
          exp_t e;
          e = beatQA.pop_front();
          checkOutput("A beat cycle", 64'(cyc - t0A), 64'(e.cyc));
          checkOutput("A beat data", 64'(mwA), 64'(e.val));
          checkOutput("A line_done", 64'(ldA), 64'(e.last));
        end
      end else if (ldA !== 1'b0) begin
        checkOutput("A line_done w/o strobe", 64'(ldA), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (reB === 1'b1) begin
        if (readQB.size() == 0) checkOutput("B unexpected read", 64'(readQB.size()), 64'd1);
        else begin
          exp_t e;
          e = readQB.pop_front();
          checkOutput("B read cycle", 64'(cyc - t0B), 64'(e.cyc));
          checkOutput("B read addr", 64'(raB), 64'(e.val));
        end
      end
      if (wrB === 1'b1) begin
        if (beatQB.size() == 0) checkOutput("B unexpected strobe", 64'(beatQB.size()), 64'd1);
        else begin
          exp_t e;
          e = beatQB.pop_front();
          checkOutput("B beat cycle", 64'(cyc - t0B), 64'(e.cyc));
          checkOutput("B beat data", 64'(mwB), 64'(e.val));
          checkOutput("B line_done", 64'(ldB), 64'(e.last));
        end
      end else if (ldB !== 1'b0) begin
        checkOutput("B line_done w/o strobe", 64'(ldB), 64'd0);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raises the miss in the current cycle (cycle 0) and drops it in cycle dropAt.
  task automatic applyStimulus(input bit dutB, input logic [31:0] addr, input int dropAt);
    if (dutB) begin
      missB = 1'b1; addrB = addr; t0B = cyc;
      pushExpect(1'b1, addr[AW-1:0], 0, dropAt);
    end else begin
      missA = 1'b1; addrA = addr; t0A = cyc;
      pushExpect(1'b0, addr[AW-1:0], 1, dropAt);
    end
    for (int rel = 0; rel < dropAt; rel++) begin
      if (rel == 0) checkOutput("busy before accept", 64'(dutB ? busyB : busyA), 64'd0);
      if (rel == 1) checkOutput("busy after accept", 64'(dutB ? busyB : busyA), 64'd1);
      if (rel == 3) begin
        if (dutB) addrB = 32'hFFFF_FFFF; else addrA = 32'hFFFF_FFFF;
      end
      waitCycles(1);
    end
    if (dutB) missB = 1'b0; else missA = 1'b0;
    waitCycles(1);
    checkOutput("busy after drop", 64'(dutB ? busyB : busyA), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst  = 1'b0;
    missA = 1'b1;
    missB = 1'b1;
    addrA = 32'h10;
    addrB = 32'h10;
    waitCycles(3);
    checkOutput("reset word_ready", 64'(wrA), 64'd0);
    checkOutput("reset line_done", 64'(ldA), 64'd0);
    checkOutput("reset busy", 64'(busyA), 64'd0);
    checkOutput("reset ram_rd_en", 64'(reA), 64'd0);
    checkOutput("reset ram_rd_addr", 64'(raA), 64'd0);
    checkOutput("reset mem_word", 64'(mwA), 64'd0);
    checkOutput("reset busy B", 64'(busyB), 64'd0);
    missA = 1'b0;
    missB = 1'b0;
    nrst  = 1'b1;
    waitCycles(2);

    $display("[TB] default burst at 0x10");
    applyStimulus(1'b0, 32'h10, 14);
    waitCycles(1);

    $display("[TB] wrap-around burst at 0x3FE");
    applyStimulus(1'b0, 32'h3FE, 12);
    waitCycles(1);

    $display("[TB] abort in cycle 5, then new miss at 0x20 in cycle 7");
    applyStimulus(1'b0, 32'h10, 5);
    waitCycles(1);
    applyStimulus(1'b0, 32'h20, 14);
    waitCycles(1);

    $display("[TB] zero-wait burst at 0x40");
    applyStimulus(1'b1, 32'h40, 10);
    waitCycles(1);

    $display("[TB] async reset pulse in cycle 5 of a burst at 0x08");
    missA = 1'b1;
    addrA = 32'h08;
    t0A   = cyc;
    pushExpect(1'b0, 10'h008, 1, 100);
    waitCycles(5);
    #1 nrst = 1'b0;
    #1;
    checkOutput("async rst busy", 64'(busyA), 64'd0);
    checkOutput("async rst word_ready", 64'(wrA), 64'd0);
    checkOutput("async rst ram_rd_en", 64'(reA), 64'd0);
    checkOutput("async rst mem_word", 64'(mwA), 64'd0);
    readQA.delete();
    beatQA.delete();
    #1 nrst = 1'b1;
    t0A = cyc;
    pushExpect(1'b0, 10'h008, 1, 100);
    waitCycles(14);
    missA = 1'b0;
    waitCycles(1);
    checkOutput("busy after restart drop", 64'(busyA), 64'd0);

    waitCycles(3);
    checkOutput("A reads pending", 64'(readQA.size()), 64'd0);
    checkOutput("A beats pending", 64'(beatQA.size()), 64'd0);
    checkOutput("B reads pending", 64'(readQB.size()), 64'd0);
    checkOutput("B beats pending", 64'(beatQB.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
